ps2_keyboard_rx: RTL and testbench

- PS/2 keyboard receiver in the pixel-clock domain, directly upstream of the example logic that drives r/g/b/hsync/vsync into the HDMI encoder.
- Oversamples the raw clkps2/dataps2 pins, glitch-filters the PS/2 clock and deserialises 11-bit frames.
- Folds the E0 (extended) and F0 (break) prefixes into flags and emits one-cycle-strobed scancodes.

---
 rtl/ps2_keyboard_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the PS/2 pins,
// deserialises 11-bit frames, folds E0/F0 prefixes into flags and strobes
// each completed scancode (kbint) or framing/timeout fault (err).
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clkps2,
   input  logic       dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       kbint,
   output logic       err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // input synchronizers and clock filter
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] run_q, run_d;
   logic          fe;

   // frame FSM and datapath
   state_t        state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          pext_q, pext_d, prel_q, prel_d;

   // output registers
   logic [7:0]    scan_q, scan_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic          kbint_q, kbint_d, err_q, err_d;

   // Filtered level flips on the FILTER_LEN-th consecutive opposite sample;
   // fe marks the cycle in which the flip is a 1->0 transition.
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (clk_s2_q != filt_q) begin
         if (run_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
            run_d  = '0;
         end else begin
            run_d = run_q + FW'(1);
         end
      end
      fe = filt_q & ~filt_d;
   end

   // Frame FSM next-state, timeout supervision and frame evaluation
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      tmo_d    = tmo_q;
      pext_d   = pext_q;
      prel_d   = prel_q;
      scan_d   = scan_q;
      ext_d    = ext_q;
      rel_d    = rel_q;
      kbint_d  = 1'b0;
      err_d    = 1'b0;

      if (state_q == IDLE) begin
         tmo_d = '0;
         if (fe && !dat_s2_q) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
            par_d    = 1'b0;
         end
      end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
         // device stopped clocking mid-frame: abandon it, any fe here is ignored
         state_d = IDLE;
         tmo_d   = '0;
         err_d   = 1'b1;
         pext_d  = 1'b0;
         prel_d  = 1'b0;
      end else begin
         tmo_d = fe ? '0 : tmo_q + TW'(1);
         if (fe) begin
            case (state_q)
               DATA: begin
                  shreg_d  = {dat_s2_q, shreg_q[7:1]};
                  par_d    = par_q ^ dat_s2_q;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = PARITY;
               end
               PARITY: begin
                  par_d   = par_q ^ dat_s2_q;
                  state_d = STOP;
               end
               STOP: begin
                  state_d = IDLE;
                  if (!dat_s2_q || !par_q) begin
                     err_d  = 1'b1;
                     pext_d = 1'b0;
                     prel_d = 1'b0;
                  end else if (shreg_q == 8'hE0) begin
                     pext_d = 1'b1;
                  end else if (shreg_q == 8'hF0) begin
                     prel_d = 1'b1;
                  end else begin
                     scan_d  = shreg_q;
                     ext_d   = pext_q;
                     rel_d   = prel_q;
                     kbint_d = 1'b1;
                     pext_d  = 1'b0;
                     prel_d  = 1'b0;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         run_q    <= '0;
         state_q  <= IDLE;
         bitcnt_q <= 3'd0;
         shreg_q  <= 8'h00;
         par_q    <= 1'b0;
         tmo_q    <= '0;
         pext_q   <= 1'b0;
         prel_q   <= 1'b0;
         scan_q   <= 8'h00;
         ext_q    <= 1'b0;
         rel_q    <= 1'b0;
         kbint_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         clk_s1_q <= clkps2;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= dataps2;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         run_q    <= run_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
         pext_q   <= pext_d;
         prel_q   <= prel_d;
         scan_q   <= scan_d;
         ext_q    <= ext_d;
         rel_q    <= rel_d;
         kbint_q  <= kbint_d;
         err_q    <= err_d;
      end
   end

   assign scancode = scan_q;
   assign extended = ext_q;
   assign released = rel_q;
   assign kbint    = kbint_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a scaled-down PS/2 bit period.
module tb_ps2_keyboard_rx;

   localparam int FL   = 8;
   localparam int TMO  = 200;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clkps2 = 1'b1;
   logic       dataps2 = 1'b1;
   logic [7:0] scancode;
   logic       extended, released, kbint, err;

   ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .clkps2(clkps2), .dataps2(dataps2),
      .scancode(scancode), .extended(extended), .released(released),
      .kbint(kbint), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int kb_cnt = 0, er_cnt = 0, both_cnt = 0;
   int kb_cyc = 0, er_cyc = 0;
   int fall_cyc = 0;
   int n_chk = 0, n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (kbint) begin kb_cnt <= kb_cnt + 1; kb_cyc <= cyc; end
      if (err)   begin er_cnt <= er_cnt + 1; er_cyc <= cyc; end
      if (kbint && err) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // nbits < 11 abandons the frame after that many falling edges
   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         dataps2 = bits[i];
         if (glitch) begin
            repeat (5) @(negedge clk);
            clkps2 = 1'b0;
            repeat (5) @(negedge clk);
            clkps2 = 1'b1;
            repeat (HALF - 10) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         clkps2   = 1'b0;
         fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         clkps2 = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      dataps2 = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic good(input logic [7:0] b);
      send(b, 1'b0, 1'b0, 11, 1'b0);
   endtask

   int kb0, er0;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_scancode", 32'(scancode), 32'h00);
      chk("rst_ext",      32'(extended), 0);
      chk("rst_rel",      32'(released), 0);
      chk("rst_kbint",    32'(kbint), 0);
      chk("rst_err",      32'(err), 0);

      // plain make code; kbint 2 sync + 8 filter cycles after the stop fall
      kb0 = kb_cnt; er0 = er_cnt;
      good(8'h1C);
      chk("1c_kbcnt",    kb_cnt - kb0, 1);
      chk("1c_errcnt",   er_cnt - er0, 0);
      chk("1c_scancode", 32'(scancode), 32'h1C);
      chk("1c_ext",      32'(extended), 0);
      chk("1c_rel",      32'(released), 0);
      chk("1c_latency",  kb_cyc - fall_cyc, 10);

      // break code, then extended break code
      kb0 = kb_cnt;
      good(8'hF0);
      chk("f0_nostrobe", kb_cnt - kb0, 0);
      good(8'h1C);
      chk("f01c_scancode", 32'(scancode), 32'h1C);
      chk("f01c_rel",      32'(released), 1);
      chk("f01c_ext",      32'(extended), 0);
      good(8'hE0);
      good(8'hF0);
      good(8'hE0);
      good(8'h75);
      chk("e0f075_scancode", 32'(scancode), 32'h75);
      chk("e0f075_ext",      32'(extended), 1);
      chk("e0f075_rel",      32'(released), 1);
      chk("break_kbcnt",     kb_cnt - kb0, 2);

      // parity error keeps outputs, then a clean frame
      kb0 = kb_cnt; er0 = er_cnt;
      send(8'h1C, 1'b1, 1'b0, 11, 1'b0);
      chk("par_errcnt",   er_cnt - er0, 1);
      chk("par_kbcnt",    kb_cnt - kb0, 0);
      chk("par_scancode", 32'(scancode), 32'h75);
      chk("par_latency",  er_cyc - fall_cyc, 10);
      good(8'h32);
      chk("32_scancode", 32'(scancode), 32'h32);
      chk("32_ext",      32'(extended), 0);
      chk("32_rel",      32'(released), 0);

      // bad stop bit drops a pending break prefix
      er0 = er_cnt;
      good(8'hF0);
      send(8'h45, 1'b0, 1'b1, 11, 1'b0);
      chk("stop_errcnt", er_cnt - er0, 1);
      good(8'h33);
      chk("33_scancode", 32'(scancode), 32'h33);
      chk("33_rel",      32'(released), 0);

      // timeout after 4 data bits drops the E0 prefix
      kb0 = kb_cnt; er0 = er_cnt;
      good(8'hE0);
      send(8'h29, 1'b0, 1'b0, 5, 1'b0);
      repeat (2 * TMO) @(negedge clk);
      chk("tmo_errcnt",  er_cnt - er0, 1);
      chk("tmo_kbcnt",   kb_cnt - kb0, 0);
      chk("tmo_latency", er_cyc - fall_cyc, 10 + TMO + 1);
      good(8'h29);
      chk("29_scancode", 32'(scancode), 32'h29);
      chk("29_ext",      32'(extended), 0);

      // short low glitches on the PS/2 clock are filtered out
      kb0 = kb_cnt; er0 = er_cnt;
      send(8'h5A, 1'b0, 1'b0, 11, 1'b1);
      chk("glitch_scancode", 32'(scancode), 32'h5A);
      chk("glitch_kbcnt",    kb_cnt - kb0, 1);
      chk("glitch_errcnt",   er_cnt - er0, 0);

      // reset mid-frame, then a clean frame
      good(8'h1C);
      kb0 = kb_cnt; er0 = er_cnt;
      send(8'h00, 1'b0, 1'b0, 4, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_scancode", 32'(scancode), 32'h00);
      chk("mrst_ext",      32'(extended), 0);
      chk("mrst_rel",      32'(released), 0);
      chk("mrst_kbint",    32'(kbint), 0);
      chk("mrst_err",      32'(err), 0);
      rst = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      chk("mrst_nostrobe", (kb_cnt - kb0) + (er_cnt - er0), 0);
      good(8'h1C);
      chk("post_rst_scancode", 32'(scancode), 32'h1C);
      chk("post_rst_kbcnt",    kb_cnt - kb0, 1);

      chk("never_both", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
